// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope with a 2-stage sample scaler, driven by a synchronised gate input.
// Define ADSR_RETRIGGER_EN to restart every note from level 0; default build is legato.
module adsr_envelope #(
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned TICK_HZ      = 1_000
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               gate,
    input  logic [7:0]         attack_step,
    input  logic [7:0]         decay_step,
    input  logic [7:0]         sustain_level,
    input  logic [7:0]         release_step,
    input  logic signed [23:0] sample_in,
    output logic signed [23:0] sample_out,
    output logic [7:0]         level,
    output logic [2:0]         state,
    output logic               active
);

    localparam int unsigned TICK_DIV = SYS_CLK_FREQ / TICK_HZ;
    localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } state_e;

    state_e           state_q;
    logic [7:0]       level_q;
    logic             active_q;
    logic [CNT_W-1:0] tick_cnt_q;
    logic             tick;
    logic             gate_meta_q, gate_sync_q, gate_prev_q;
    logic             gate_rise, gate_fall;
    logic [8:0]       attack_sum, decay_diff, release_diff;
    logic signed [23:0] sample_q;
    logic [8:0]       gain_q;
    logic signed [32:0] product;

    assign tick      = (tick_cnt_q == CNT_MAX);
    assign gate_rise = gate_sync_q & ~gate_prev_q;
    assign gate_fall = ~gate_sync_q & gate_prev_q;

    // Bit 8 of the differences is the borrow, i.e. the step overshot zero.
    assign attack_sum   = {1'b0, level_q} + {1'b0, attack_step};
    assign decay_diff   = {1'b0, level_q} - {1'b0, decay_step};
    assign release_diff = {1'b0, level_q} - {1'b0, release_step};

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            gate_meta_q <= 1'b0;
            gate_sync_q <= 1'b0;
            gate_prev_q <= 1'b0;
        end else begin
            gate_meta_q <= gate;
            gate_sync_q <= gate_meta_q;
            gate_prev_q <= gate_sync_q;
        end
    end

    // Gate edges take priority over the tick; no level step on an edge cycle.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            level_q  <= 8'd0;
            active_q <= 1'b0;
        end else if (gate_rise) begin
            state_q  <= StAttack;
            active_q <= 1'b1;
`ifdef ADSR_RETRIGGER_EN
            level_q  <= 8'd0;
`endif
        end else if (gate_fall &&
                     (state_q == StAttack || state_q == StDecay || state_q == StSustain)) begin
            state_q <= StRelease;
        end else if (tick) begin
            unique case (state_q)
                StIdle: begin
                    level_q <= 8'd0;
                end
                StAttack: begin
                    if (attack_step == 8'd0 || attack_sum >= 9'd255) begin
                        level_q <= 8'd255;
                        state_q <= StDecay;
                    end else begin
                        level_q <= attack_sum[7:0];
                    end
                end
                StDecay: begin
                    if (decay_step == 8'd0 || decay_diff[8] || decay_diff[7:0] <= sustain_level) begin
                        level_q <= sustain_level;
                        state_q <= StSustain;
                    end else begin
                        level_q <= decay_diff[7:0];
                    end
                end
                StSustain: begin
                    level_q <= sustain_level;
                end
                StRelease: begin
                    if (release_step == 8'd0 || release_diff[8] || release_diff[7:0] == 8'd0) begin
                        level_q  <= 8'd0;
                        state_q  <= StIdle;
                        active_q <= 1'b0;
                    end else begin
                        level_q <= release_diff[7:0];
                    end
                end
                default: begin
                    level_q  <= 8'd0;
                    state_q  <= StIdle;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Level 255 maps to a gain of 256 so full scale is exact unity.
    assign product = $signed({{9{sample_q[23]}}, sample_q}) * $signed({24'd0, gain_q});

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sample_q   <= '0;
            gain_q     <= '0;
            sample_out <= '0;
        end else begin
            sample_q   <= sample_in;
            gain_q     <= (level_q == 8'd255) ? 9'd256 : {1'b0, level_q};
            sample_out <= 24'(product >>> 8);
        end
    end

    assign level  = level_q;
    assign state  = state_q;
    assign active = active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: tick every 10 cycles (SYS_CLK_FREQ=1000, TICK_HZ=100).
// Expected legato/retrigger levels follow ADSR_RETRIGGER_EN.
module tb_adsr_envelope;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               gate;
    logic [7:0]         attack_step, decay_step, sustain_level, release_step;
    logic signed [23:0] sample_in;
    logic signed [23:0] sample_out;
    logic [7:0]         level;
    logic [2:0]         state;
    logic               active;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    localparam logic [7:0] AD_LVL [12] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd239, 8'd223,
                                          8'd207, 8'd191, 8'd175, 8'd159, 8'd143, 8'd128};
    localparam logic [2:0] AD_ST  [12] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                                          3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    localparam logic [7:0] REL_LVL [4] = '{8'd96, 8'd64, 8'd32, 8'd0};
    localparam logic [2:0] REL_ST  [4] = '{3'd4, 3'd4, 3'd4, 3'd0};
    localparam logic       REL_ACT [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

`ifdef ADSR_RETRIGGER_EN
    localparam logic [7:0] RETRIG_ENTRY = 8'd0;
    localparam logic [7:0] RETRIG_TICK  = 8'd64;
    localparam logic [7:0] EDGE_HOLD    = 8'd64;
    localparam logic [7:0] EDGE_NEXT    = 8'd32;
`else
    localparam logic [7:0] RETRIG_ENTRY = 8'd64;
    localparam logic [7:0] RETRIG_TICK  = 8'd128;
    localparam logic [7:0] EDGE_HOLD    = 8'd128;
    localparam logic [7:0] EDGE_NEXT    = 8'd96;
`endif

    adsr_envelope #(
        .SYS_CLK_FREQ(1000),
        .TICK_HZ     (100)
    ) dut (
        .sys_clk      (clk),
        .reset        (rst_n),
        .gate         (gate),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .sustain_level(sustain_level),
        .release_step (release_step),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .level        (level),
        .state        (state),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic clk_cycle;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic next_tick;
        do clk_cycle(); while (cyc % 10 != 0);
    endtask

    task automatic adv_mod(input int m);
        while (cyc % 10 != m) clk_cycle();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; gate = 1'b1; sample_in = 24'sh100000;
        attack_step = 8'd64; decay_step = 8'd16; sustain_level = 8'd128; release_step = 8'd32;
        repeat (3) clk_cycle();
        n_cmp++; if (sample_out !== 24'sd0) begin n_bad++; $display("FAIL rst_sample: got %0d want 0", sample_out); end
        n_cmp++; if (level !== 8'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", level); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL rst_active: got %b want 0", active); end
        rst_n = 1'b1;
        cyc = 0;
        repeat (2) clk_cycle();
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL sync_early: got %0d want 0", state); end
        clk_cycle();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL sync_attack: got %0d want 1", state); end
        n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL sync_active: got %b want 1", active); end
    endtask

    task automatic test_attack_decay;
        for (int i = 0; i < 12; i++) begin
            next_tick();
            n_cmp++; if (level !== AD_LVL[i]) begin n_bad++; $display("FAIL ad_level[%0d]: got %0d want %0d", i, level, AD_LVL[i]); end
            n_cmp++; if (state !== AD_ST[i]) begin n_bad++; $display("FAIL ad_state[%0d]: got %0d want %0d", i, state, AD_ST[i]); end
        end
    endtask

    task automatic test_scaling;
        repeat (2) clk_cycle();
        n_cmp++; if (sample_out !== 24'sh080000) begin n_bad++; $display("FAIL scale_half_fs: got %0d want 524288", sample_out); end
        sample_in = 24'sd1001;
        clk_cycle();
        n_cmp++; if (sample_out !== 24'sh080000) begin n_bad++; $display("FAIL scale_latency: got %0d want 524288", sample_out); end
        clk_cycle();
        n_cmp++; if (sample_out !== 24'sd500) begin n_bad++; $display("FAIL scale_pos: got %0d want 500", sample_out); end
        sample_in = -24'sd1001;
        repeat (2) clk_cycle();
        n_cmp++; if (sample_out !== -24'sd501) begin n_bad++; $display("FAIL scale_neg: got %0d want -501", sample_out); end
        sustain_level = 8'd255;
        next_tick();
        n_cmp++; if (level !== 8'd255) begin n_bad++; $display("FAIL sustain_track: got %0d want 255", level); end
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL sustain_state: got %0d want 3", state); end
        sample_in = -24'sd1000;
        repeat (2) clk_cycle();
        n_cmp++; if (sample_out !== -24'sd1000) begin n_bad++; $display("FAIL scale_unity: got %0d want -1000", sample_out); end
        sustain_level = 8'd128;
        next_tick();
        n_cmp++; if (level !== 8'd128) begin n_bad++; $display("FAIL sustain_back: got %0d want 128", level); end
    endtask

    task automatic test_release;
        gate = 1'b0;
        repeat (3) clk_cycle();
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL rel_enter: got %0d want 4", state); end
        n_cmp++; if (level !== 8'd128) begin n_bad++; $display("FAIL rel_hold: got %0d want 128", level); end
        for (int i = 0; i < 4; i++) begin
            next_tick();
            n_cmp++; if (level !== REL_LVL[i]) begin n_bad++; $display("FAIL rel_level[%0d]: got %0d want %0d", i, level, REL_LVL[i]); end
            n_cmp++; if (state !== REL_ST[i]) begin n_bad++; $display("FAIL rel_state[%0d]: got %0d want %0d", i, state, REL_ST[i]); end
            n_cmp++; if (active !== REL_ACT[i]) begin n_bad++; $display("FAIL rel_active[%0d]: got %b want %b", i, active, REL_ACT[i]); end
        end
        sample_in = 24'sd1001;
        repeat (2) clk_cycle();
        n_cmp++; if (sample_out !== 24'sd0) begin n_bad++; $display("FAIL scale_zero: got %0d want 0", sample_out); end
    endtask

    task automatic test_retrigger;
        attack_step = 8'd0; decay_step = 8'd0;
        gate = 1'b1;
        repeat (3) clk_cycle();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL rt_attack: got %0d want 1", state); end
        next_tick();
        n_cmp++; if (level !== 8'd255) begin n_bad++; $display("FAIL atk_zero_lvl: got %0d want 255", level); end
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL atk_zero_st: got %0d want 2", state); end
        next_tick();
        n_cmp++; if (level !== 8'd128) begin n_bad++; $display("FAIL dec_zero_lvl: got %0d want 128", level); end
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL dec_zero_st: got %0d want 3", state); end
        gate = 1'b0;
        repeat (3) clk_cycle();
        next_tick();
        next_tick();
        n_cmp++; if (level !== 8'd64) begin n_bad++; $display("FAIL rt_pre: got %0d want 64", level); end
        gate = 1'b1;
        repeat (3) clk_cycle();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL rt_state: got %0d want 1", state); end
        n_cmp++; if (level !== RETRIG_ENTRY) begin n_bad++; $display("FAIL rt_entry: got %0d want %0d", level, RETRIG_ENTRY); end
        attack_step = 8'd64;
        next_tick();
        n_cmp++; if (level !== RETRIG_TICK) begin n_bad++; $display("FAIL rt_tick: got %0d want %0d", level, RETRIG_TICK); end
    endtask

    task automatic test_edge_tick;
        adv_mod(7);
        gate = 1'b0;
        repeat (3) clk_cycle();
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL et_fall_st: got %0d want 4", state); end
        n_cmp++; if (level !== EDGE_HOLD) begin n_bad++; $display("FAIL et_fall_lvl: got %0d want %0d", level, EDGE_HOLD); end
        next_tick();
        n_cmp++; if (level !== EDGE_NEXT) begin n_bad++; $display("FAIL et_next: got %0d want %0d", level, EDGE_NEXT); end
        release_step = 8'd0;
        next_tick();
        n_cmp++; if (level !== 8'd0) begin n_bad++; $display("FAIL rel_zero_lvl: got %0d want 0", level); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rel_zero_st: got %0d want 0", state); end
        attack_step = 8'd0;
        adv_mod(7);
        gate = 1'b1;
        repeat (3) clk_cycle();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL et_rise_st: got %0d want 1", state); end
        n_cmp++; if (level !== 8'd0) begin n_bad++; $display("FAIL et_rise_lvl: got %0d want 0", level); end
        next_tick();
        n_cmp++; if (level !== 8'd255) begin n_bad++; $display("FAIL et_atk0: got %0d want 255", level); end
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL et_atk0_st: got %0d want 2", state); end
    endtask

    task automatic test_reset_mid_note;
        next_tick();
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL mid_sustain: got %0d want 3", state); end
        sample_in = 24'sd1001;
        repeat (2) clk_cycle();
        n_cmp++; if (sample_out !== 24'sd500) begin n_bad++; $display("FAIL mid_sample: got %0d want 500", sample_out); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (level !== 8'd0) begin n_bad++; $display("FAIL mid_rst_lvl: got %0d want 0", level); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL mid_rst_st: got %0d want 0", state); end
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL mid_rst_act: got %b want 0", active); end
        n_cmp++; if (sample_out !== 24'sd0) begin n_bad++; $display("FAIL mid_rst_out: got %0d want 0", sample_out); end
    endtask

    initial begin
        test_reset();
        test_attack_decay();
        test_scaling();
        test_release();
        test_retrigger();
        test_edge_tick();
        test_reset_mid_note();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
